// File: rtl/mul_div_controller.sv
// Iterative MIPS-style multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per RUN cycle; signs are fixed up in FIX.
module mul_div_controller (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Flush,
    input  logic        HiLoRead,
    input  logic        HiWrite,
    input  logic        LoWrite,
    input  logic [31:0] WriteData,
    output logic        Busy,
    output logic        StallReq,
    output logic        Done,
    output logic        DivByZero,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

    state_t      state, next_state;
    logic        accept;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q, m_q;
    logic [31:0] acc_hi, acc_lo;
    logic [5:0]  count;
    logic        neg_res, neg_rem, div_zero;

    logic        is_div, signed_op;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum, div_shift, div_diff;
    logic [63:0] product, product_fix;
    logic [31:0] quo_fix, rem_fix;

    assign is_div    = op_q[1];
    assign signed_op = ~op_q[0];

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                if (Start && !Flush) begin
                    accept     = 1'b1;
                    next_state = PREP;
                end
            end
            PREP: begin
                Busy = 1'b1;
                if (Flush)                     next_state = IDLE;
                else if (is_div && b_q == '0)  next_state = FIX;
                else                           next_state = RUN;
            end
            RUN: begin
                Busy = 1'b1;
                if (Flush)              next_state = IDLE;
                else if (count == 6'd0) next_state = FIX;
            end
            FIX: begin
                Busy       = 1'b1;
                next_state = Flush ? IDLE : DONE;
            end
            DONE: begin
                Done = 1'b1;
                if (Start && !Flush) begin
                    accept     = 1'b1;
                    next_state = PREP;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign StallReq  = Busy & (HiLoRead | Start | HiWrite | LoWrite);
    assign DivByZero = Done & div_zero;

    assign mag_a = (signed_op && a_q[31]) ? (~a_q + 32'd1) : a_q;
    assign mag_b = (signed_op && b_q[31]) ? (~b_q + 32'd1) : b_q;

    // m_q holds the multiplicand or the divisor; acc_lo starts as multiplier or dividend
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_q} : 33'd0);
    assign div_shift = {acc_hi, acc_lo[31]};
    assign div_diff  = div_shift - {1'b0, m_q};

    assign product     = {acc_hi, acc_lo};
    assign product_fix = neg_res ? (~product + 64'd1) : product;
    assign quo_fix     = neg_res ? (~acc_lo + 32'd1) : acc_lo;
    assign rem_fix     = neg_rem ? (~acc_hi + 32'd1) : acc_hi;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            count    <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= Op;
                a_q  <= A;
                b_q  <= B;
            end
            if (state == PREP) begin
                count    <= 6'd31;
                neg_res  <= signed_op & (a_q[31] ^ b_q[31]);
                neg_rem  <= signed_op & a_q[31];
                div_zero <= is_div & (b_q == '0);
                acc_hi   <= '0;
                m_q      <= is_div ? mag_b : mag_a;
                acc_lo   <= is_div ? mag_a : mag_b;
            end else if (state == RUN) begin
                if (count != 6'd0) count <= count - 6'd1;
                if (is_div) begin
                    if (!div_diff[32]) begin
                        acc_hi <= div_diff[31:0];
                        acc_lo <= {acc_lo[30:0], 1'b1};
                    end else begin
                        acc_hi <= div_shift[31:0];
                        acc_lo <= {acc_lo[30:0], 1'b0};
                    end
                end else begin
                    acc_hi <= mul_sum[32:1];
                    acc_lo <= {mul_sum[0], acc_lo[31:1]};
                end
            end
        end
    end

    // Results land at the end of FIX; mthi/mtlo only get through while the unit is idle
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            HI <= '0;
            LO <= '0;
        end else if (state == FIX && !Flush) begin
            if (div_zero) begin
                HI <= a_q;
                LO <= 32'hFFFF_FFFF;
            end else if (is_div) begin
                HI <= rem_fix;
                LO <= quo_fix;
            end else begin
                HI <= product_fix[63:32];
                LO <= product_fix[31:0];
            end
        end else if (!Busy) begin
            if (HiWrite) HI <= WriteData;
            if (LoWrite) LO <= WriteData;
        end
    end

endmodule

// File: tb/tb_mul_div_controller.sv
// Directed bench for mul_div_controller: arithmetic results, cycle timing, stalls,
// flush, async reset and HI/LO writes around the DONE state.
module tb_mul_div_controller;

    logic        Clk, Rst, Start, Flush, HiLoRead, HiWrite, LoWrite;
    logic [1:0]  Op;
    logic [31:0] A, B, WriteData;
    logic        Busy, StallReq, Done, DivByZero;
    logic [31:0] HI, LO;

    int vectors;
    int miscompares;

    mul_div_controller dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .Flush(Flush), .HiLoRead(HiLoRead), .HiWrite(HiWrite), .LoWrite(LoWrite),
        .WriteData(WriteData), .Busy(Busy), .StallReq(StallReq), .Done(Done),
        .DivByZero(DivByZero), .HI(HI), .LO(LO)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Drives Start for one cycle from the current negedge, then follows the
    // operation (cycle 1 = PREP) until Done or a 100-cycle budget runs out.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output int busy_cnt, output logic dbz);
        Start = 1'b1; Op = op; A = a; B = b;
        @(negedge Clk);
        Start = 1'b0;
        cyc = 1; busy_cnt = 0; dbz = 1'b0;
        while (cyc < 100) begin
            if (Busy) busy_cnt++;
            if (Done) begin
                dbz = DivByZero;
                break;
            end
            @(negedge Clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        #3;
        vectors++;
        if ({Busy, StallReq, Done, DivByZero} !== 4'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {Busy, StallReq, Done, DivByZero});
        end
        vectors++;
        if (HI !== 32'h0 || LO !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_hilo: got %h_%h expected 0_0", HI, LO);
        end
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic test_mult;
        int cyc, bc; logic dbz;
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, cyc, bc, dbz);
        vectors++;
        if (cyc !== 35) begin
            miscompares++;
            $display("[TB] FAIL mult_done_cycle: got %0d expected 35", cyc);
        end
        vectors++;
        if (bc !== 34) begin
            miscompares++;
            $display("[TB] FAIL mult_busy_cycles: got %0d expected 34", bc);
        end
        vectors++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFEB) begin
            miscompares++;
            $display("[TB] FAIL mult_neg: got %h_%h expected ffffffff_ffffffeb", HI, LO);
        end
        @(negedge Clk);
        vectors++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL done_one_cycle: got done=%b busy=%b expected 0 0", Done, Busy);
        end
        run_op(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, cyc, bc, dbz);
        vectors++;
        if (HI !== 32'h0 || LO !== 32'h6) begin
            miscompares++;
            $display("[TB] FAIL mult_negneg: got %h_%h expected 0_6", HI, LO);
        end
        @(negedge Clk);
    endtask

    task automatic test_multu_divu;
        int cyc, bc; logic dbz;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bc, dbz);
        vectors++;
        if (HI !== 32'hFFFF_FFFE || LO !== 32'h1) begin
            miscompares++;
            $display("[TB] FAIL multu_max: got %h_%h expected fffffffe_00000001", HI, LO);
        end
        @(negedge Clk);
        run_op(2'b11, 32'd100, 32'd7, cyc, bc, dbz);
        vectors++;
        if (HI !== 32'h2 || LO !== 32'hE || dbz !== 1'b0 || cyc !== 35) begin
            miscompares++;
            $display("[TB] FAIL divu_100_7: got %h_%h dbz=%b cyc=%0d expected 2_e dbz=0 cyc=35",
                     HI, LO, dbz, cyc);
        end
        @(negedge Clk);
    endtask

    task automatic test_div_signed;
        int cyc, bc; logic dbz;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, cyc, bc, dbz);
        vectors++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
            miscompares++;
            $display("[TB] FAIL div_neg7_2: got %h_%h expected ffffffff_fffffffd", HI, LO);
        end
        @(negedge Clk);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, cyc, bc, dbz);
        vectors++;
        if (HI !== 32'h1 || LO !== 32'hFFFF_FFFD) begin
            miscompares++;
            $display("[TB] FAIL div_7_neg2: got %h_%h expected 00000001_fffffffd", HI, LO);
        end
        @(negedge Clk);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bc, dbz);
        vectors++;
        if (HI !== 32'h0 || LO !== 32'h8000_0000) begin
            miscompares++;
            $display("[TB] FAIL div_overflow: got %h_%h expected 0_80000000", HI, LO);
        end
        @(negedge Clk);
    endtask

    task automatic test_div_zero;
        int cyc, bc; logic dbz;
        run_op(2'b11, 32'd5, 32'd0, cyc, bc, dbz);
        vectors++;
        if (cyc !== 3 || dbz !== 1'b1 || bc !== 2) begin
            miscompares++;
            $display("[TB] FAIL divzero_timing: got cyc=%0d dbz=%b busy=%0d expected 3 1 2", cyc, dbz, bc);
        end
        vectors++;
        if (HI !== 32'h5 || LO !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("[TB] FAIL divzero_result: got %h_%h expected 5_ffffffff", HI, LO);
        end
        @(negedge Clk);
    endtask

    // HiLoRead held across the whole operation; a stray Start and a held mthi must be ignored
    task automatic test_stall;
        int cyc, stall_cnt;
        HiLoRead = 1'b1;
        #1;
        vectors++;
        if (StallReq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stall_idle: got %b expected 0", StallReq);
        end
        Start = 1'b1; Op = 2'b11; A = 32'd100; B = 32'd7;
        @(negedge Clk);
        Start = 1'b0; HiWrite = 1'b1; WriteData = 32'hDEAD_BEEF; A = 32'd1000;
        cyc = 1; stall_cnt = 0;
        while (cyc < 100) begin
            if (cyc == 20) Start = 1'b1;
            if (cyc == 21) Start = 1'b0;
            if (cyc == 34) HiWrite = 1'b0;
            #1;
            if (StallReq) stall_cnt++;
            if (Done) break;
            @(negedge Clk);
            cyc++;
        end
        HiLoRead = 1'b0;
        vectors++;
        if (stall_cnt !== 34 || cyc !== 35) begin
            miscompares++;
            $display("[TB] FAIL stall_window: got stall=%0d done_cyc=%0d expected 34 35", stall_cnt, cyc);
        end
        vectors++;
        if (HI !== 32'h2 || LO !== 32'hE) begin
            miscompares++;
            $display("[TB] FAIL busy_ignores_writes: got %h_%h expected 2_e", HI, LO);
        end
        @(negedge Clk);
    endtask

    task automatic test_flush;
        int cyc, done_cnt;
        HiWrite = 1'b1; WriteData = 32'h1111_2222;
        @(negedge Clk);
        HiWrite = 1'b0; LoWrite = 1'b1; WriteData = 32'h3333_4444;
        @(negedge Clk);
        LoWrite = 1'b0;
        vectors++;
        if (HI !== 32'h1111_2222 || LO !== 32'h3333_4444) begin
            miscompares++;
            $display("[TB] FAIL mthi_mtlo_idle: got %h_%h expected 11112222_33334444", HI, LO);
        end
        Start = 1'b1; Op = 2'b00; A = 32'd3; B = 32'd5;
        @(negedge Clk);
        Start = 1'b0;
        for (int c = 2; c <= 10; c++) @(negedge Clk);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        vectors++;
        if (Busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_to_idle: got busy=%b expected 0", Busy);
        end
        done_cnt = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (Done) done_cnt++;
            @(negedge Clk);
        end
        vectors++;
        if (done_cnt !== 0 || HI !== 32'h1111_2222 || LO !== 32'h3333_4444) begin
            miscompares++;
            $display("[TB] FAIL flush_no_result: got done=%0d hilo=%h_%h expected 0 11112222_33334444",
                     done_cnt, HI, LO);
        end
    endtask

    // In DONE: Flush blocks the Start but mtlo still lands
    task automatic test_mtlo_done;
        int cyc, bc; logic dbz;
        run_op(2'b11, 32'd100, 32'd7, cyc, bc, dbz);
        Flush = 1'b1; Start = 1'b1; Op = 2'b00; LoWrite = 1'b1; WriteData = 32'h1234;
        @(negedge Clk);
        Flush = 1'b0; Start = 1'b0; LoWrite = 1'b0;
        vectors++;
        if (Busy !== 1'b0 || LO !== 32'h1234 || HI !== 32'h2) begin
            miscompares++;
            $display("[TB] FAIL mtlo_in_done: got busy=%b hilo=%h_%h expected 0 2_1234", Busy, HI, LO);
        end
        @(negedge Clk);
    endtask

    task automatic test_back_to_back;
        int cyc, bc; logic dbz;
        run_op(2'b01, 32'd2, 32'd3, cyc, bc, dbz);
        Start = 1'b1; Op = 2'b11; A = 32'd50; B = 32'd8; HiWrite = 1'b1; WriteData = 32'hCAFE;
        @(negedge Clk);
        Start = 1'b0; HiWrite = 1'b0;
        vectors++;
        if (Busy !== 1'b1 || HI !== 32'hCAFE || LO !== 32'h6) begin
            miscompares++;
            $display("[TB] FAIL b2b_accept: got busy=%b hilo=%h_%h expected 1 0000cafe_6", Busy, HI, LO);
        end
        cyc = 1;
        while (cyc < 100 && !Done) begin
            @(negedge Clk);
            cyc++;
        end
        vectors++;
        if (cyc !== 35 || HI !== 32'h2 || LO !== 32'h6) begin
            miscompares++;
            $display("[TB] FAIL b2b_result: got cyc=%0d hilo=%h_%h expected 35 2_6", cyc, HI, LO);
        end
        @(negedge Clk);
    endtask

    task automatic test_async_reset;
        int done_cnt;
        Start = 1'b1; Op = 2'b01; A = 32'd9; B = 32'd9;
        @(negedge Clk);
        Start = 1'b0; HiLoRead = 1'b1;
        for (int c = 2; c <= 12; c++) @(negedge Clk);
        #2 Rst = 1'b0;
        #1;
        vectors++;
        if ({Busy, StallReq, Done, DivByZero} !== 4'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got flags=%b hilo=%h_%h expected 0000 0_0",
                     {Busy, StallReq, Done, DivByZero}, HI, LO);
        end
        @(negedge Clk);
        Rst = 1'b1; HiLoRead = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (Done || Busy) done_cnt++;
            @(negedge Clk);
        end
        vectors++;
        if (done_cnt !== 0) begin
            miscompares++;
            $display("[TB] FAIL reset_discard: got %0d active cycles expected 0", done_cnt);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        Rst = 1'b0; Start = 1'b0; Flush = 1'b0; HiLoRead = 1'b0;
        HiWrite = 1'b0; LoWrite = 1'b0; Op = 2'b00; A = '0; B = '0; WriteData = '0;
        test_reset;
        test_mult;
        test_multu_divu;
        test_div_signed;
        test_div_zero;
        test_stall;
        test_flush;
        test_mtlo_done;
        test_back_to_back;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_div_controller.md
MUL_DIV_CONTROLLER -- requirements
Module: mul_div_controller

Interface
REQ-001 SHALL have port Clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port Rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port Start, input, 1, ID/EX issues a mult/div operation this cycle.
REQ-004 SHALL have port Op, input, 2, operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port A, input, 32, rs operand (multiplicand / dividend).
REQ-006 SHALL have port B, input, 32, rt operand (multiplier / divisor).
REQ-007 SHALL have port Flush, input, 1, pipeline flush; aborts the in-flight operation.
REQ-008 SHALL have port HiLoRead, input, 1, ID stage holds mfhi/mflo.
REQ-009 SHALL have port HiWrite, input, 1, mthi request.
REQ-010 SHALL have port LoWrite, input, 1, mtlo request.
REQ-011 SHALL have port WriteData, input, 32, mthi/mtlo data.
REQ-012 SHALL have port Busy, output, 1, operation in progress.
REQ-013 SHALL have port StallReq, output, 1, request to the hazard unit to hold PC and IF/ID.
REQ-014 SHALL have port Done, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port DivByZero, output, 1, qualifies Done for div with B==0.
REQ-016 SHALL have ports HI and LO, output, 32 each, architectural HI/LO registers.

Function
REQ-017 SHALL implement FSM states IDLE, PREP, RUN, FIX, DONE.
REQ-018 SHALL accept Start only in IDLE or DONE with Flush=0; accepted operands and Op are latched and the next state is PREP.
REQ-019 SHALL, in PREP, form unsigned magnitudes (signed ops: two's-complement absolute value) and record result signs; it SHALL load a 6-bit iteration counter with 31.
REQ-020 SHALL, in PREP, go directly to FIX if Op is DIV/DIVU and B==0; otherwise it SHALL go to RUN.
REQ-021 SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per RUN cycle; it SHALL stay in RUN for exactly 32 cycles (counter 31 down to 0) and then go to FIX.
REQ-022 SHALL, in FIX, apply sign correction and write HI/LO at the end of the cycle.
REQ-023 Multiply results SHALL be HI = product[63:32] and LO = product[31:0].
REQ-024 Divide results SHALL be LO = quotient and HI = remainder.
REQ-025 Signed quotient SHALL be negative iff operand signs differ; the remainder SHALL take the dividend's sign.
REQ-026 0x80000000 / 0xFFFFFFFF (DIV) SHALL yield LO = 0x80000000 and HI = 0.
REQ-027 Divide by zero SHALL yield HI = A, LO = 0xFFFFFFFF, and DivByZero = 1 together with Done.
REQ-028 Timing with Start sampled at the end of cycle 0: PREP is cycle 1, RUN is cycles 2-33, FIX is cycle 34, DONE (Done=1) is cycle 35; for divide by zero, FIX is cycle 2 and DONE is cycle 3.
REQ-029 DONE SHALL last one cycle and then go to IDLE, or to PREP if a new Start is accepted.
REQ-030 Busy SHALL be 1 in PREP, RUN and FIX only.
REQ-031 StallReq SHALL equal Busy & (HiLoRead | Start | HiWrite | LoWrite), combinationally.
REQ-032 Start, HiWrite and LoWrite SHALL be ignored while Busy.
REQ-033 HiWrite/LoWrite SHALL update HI/LO from WriteData at the clock edge when not Busy, including in DONE.
REQ-034 If Start and HiWrite/LoWrite are both asserted in an accepting state, the write SHALL take effect and the operation SHALL start.
REQ-035 Flush in PREP, RUN or FIX SHALL return the FSM to IDLE at the next edge, leave HI/LO unchanged, and produce no Done.
REQ-036 Flush in IDLE or DONE SHALL block Start acceptance and SHALL NOT block HiWrite/LoWrite.

Reset
REQ-037 Rst=0 SHALL immediately force state IDLE, counter 0, HI=LO=0, and Busy=StallReq=Done=DivByZero=0.
REQ-038 Reset asserted mid-operation SHALL discard that operation with no Done after release.
REQ-039 The first Start SHALL be accepted on the first rising edge with Rst=1.

Verification
REQ-040 MULT A=0xFFFFFFFD, B=7 -> Done in cycle 35, HI=0xFFFFFFFF, LO=0xFFFFFFEB, Busy high in cycles 1-34.
REQ-041 MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; DIVU 100/7 -> LO=0xE, HI=0x2.
REQ-042 DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-043 DIVU A=5, B=0 -> Done and DivByZero in cycle 3, HI=5, LO=0xFFFFFFFF.
REQ-044 HiLoRead=1 during RUN -> StallReq=1 until FIX ends; Flush in RUN cycle 10 -> IDLE next cycle, HI/LO keep prior values, no Done.
REQ-045 Rst low mid-RUN -> all outputs 0 asynchronously; MTLO 0x1234 in DONE -> LO=0x1234 on the next edge.
